// File: rtl/player_motion_if.sv
// Signal bundle between the motion stage and its environment (keys, frame strobe,
// collider bounds in; registered position, status and debug state out).
interface player_motion_if;
  // frame_clk is a level strobe, not a valid/ready handshake: the stage updates once on
  // each 0->1 transition seen at Clk, and respawn is a one-cycle pulse with no acknowledge.
  logic frame_clk;
  logic respawn;
  logic key_left;
  logic key_right;
  logic key_jump;
  int   player_X_Min;
  int   player_X_Max;
  int   player_Y_Min;
  int   player_Y_Max;
  int   player_X_Pos;
  int   player_Y_Pos;
  logic on_ground;
  logic facing_left;
  logic dbg_state;
  int   dbg_vel_y;

  modport master (
    output frame_clk, respawn, key_left, key_right, key_jump,
    output player_X_Min, player_X_Max, player_Y_Min, player_Y_Max,
    input  player_X_Pos, player_Y_Pos, on_ground, facing_left, dbg_state, dbg_vel_y
  );

  modport slave (
    input  frame_clk, respawn, key_left, key_right, key_jump,
    input  player_X_Min, player_X_Max, player_Y_Min, player_Y_Max,
    output player_X_Pos, player_Y_Pos, on_ground, facing_left, dbg_state, dbg_vel_y
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player motion: horizontal walking, gravity, jumping and floor/ceiling
// handling against the bounds box supplied by the collider.
module player_motion #(
    parameter int X_INIT     = 32,
    parameter int Y_INIT     = 415,
    parameter int X_STEP     = 2,
    parameter int JUMP_SPEED = 8,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 8
) (
    input logic Clk,
    input logic Reset_n,
    player_motion_if.slave bus
);

    typedef enum logic {AIR = 1'b0, GROUND = 1'b1} state_t;

    state_t state_q, state_n;
    int     x_q, x_n;
    int     y_q, y_n;
    int     vel_q, vel_n;
    logic   armed_q, armed_n;
    logic   facing_q, facing_n;
    logic   frame_d;
    logic   tick;
    int     dx, x_t, y_t, v_t;

    assign tick = bus.frame_clk & ~frame_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= AIR;
            x_q      <= X_INIT;
            y_q      <= Y_INIT;
            vel_q    <= 0;
            armed_q  <= 1'b1;
            facing_q <= 1'b0;
            frame_d  <= 1'b0;
        end else begin
            state_q  <= state_n;
            x_q      <= x_n;
            y_q      <= y_n;
            vel_q    <= vel_n;
            armed_q  <= armed_n;
            facing_q <= facing_n;
            frame_d  <= bus.frame_clk;
        end
    end

    always_comb begin
        state_n  = state_q;
        x_n      = x_q;
        y_n      = y_q;
        vel_n    = vel_q;
        facing_n = facing_q;
        // Re-arming on any released cycle makes a held jump key fire only once.
        armed_n  = armed_q | ~bus.key_jump;
        dx       = 0;
        x_t      = 0;
        y_t      = 0;
        v_t      = 0;
        if (bus.respawn) begin
            x_n     = X_INIT;
            y_n     = Y_INIT;
            vel_n   = 0;
            state_n = AIR;
        end else if (tick) begin
            if (bus.key_right && !bus.key_left) begin
                dx       = X_STEP;
                facing_n = 1'b0;
            end else if (bus.key_left && !bus.key_right) begin
                dx       = -X_STEP;
                facing_n = 1'b1;
            end
            // Max first, then Min, so Min wins when the collider hands back inverted bounds.
            x_t = x_q + dx;
            if (x_t > bus.player_X_Max) x_t = bus.player_X_Max;
            if (x_t < bus.player_X_Min) x_t = bus.player_X_Min;
            x_n = x_t;

            if (state_q == GROUND) begin
                if (bus.key_jump && armed_q) begin
                    y_t = y_q - JUMP_SPEED;
                    if (y_t < bus.player_Y_Min) y_t = bus.player_Y_Min;
                    y_n     = y_t;
                    vel_n   = GRAVITY - JUMP_SPEED;
                    armed_n = 1'b0;
                    state_n = AIR;
                end else if (y_q < bus.player_Y_Max) begin
                    vel_n   = 0;
                    state_n = AIR;
                end else begin
                    y_n = bus.player_Y_Max;
                end
            end else begin
                y_t = y_q + vel_q;
                if (vel_q >= 0 && y_t >= bus.player_Y_Max) begin
                    y_n     = bus.player_Y_Max;
                    vel_n   = 0;
                    state_n = GROUND;
                end else if (vel_q < 0 && y_t <= bus.player_Y_Min) begin
                    y_n   = bus.player_Y_Min;
                    vel_n = 0;
                end else begin
                    y_n = y_t;
                    v_t = vel_q + GRAVITY;
                    if (v_t > MAX_FALL) v_t = MAX_FALL;
                    vel_n = v_t;
                end
            end
        end
    end

    assign bus.player_X_Pos = x_q;
    assign bus.player_Y_Pos = y_q;
    assign bus.on_ground    = (state_q == GROUND);
    assign bus.facing_left  = facing_q;
    assign bus.dbg_state    = state_q;
    assign bus.dbg_vel_y    = vel_q;

endmodule
